// File: rtl/rom_reader_if.sv
// rom_reader_if: bundles the ROM read port and the valid/ready output stream
// of rom_reader.
//   rom_en/rom_addr  : read request from initiator to ROM
//   rom_dout         : ROM read data back to initiator
//   out_data/out_valid/out_ready : word stream to downstream consumer
// master = the reader (rom_reader), slave = the environment (ROM + consumer).
interface rom_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rom_en, rom_addr, out_data, out_valid,
    input  rom_dout, out_ready
  );

  modport slave (
    input  rom_en, rom_addr, out_data, out_valid,
    output rom_dout, out_ready
  );
endinterface

// File: rtl/rom_reader.sv
// rom_reader: reads a run of consecutive addresses from a synchronous ROM
// and streams each word out on a valid/ready interface, one read in flight.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : command strobe, sampled only in IDLE
//   start_addr : first address of the run
//   count      : number of words to read (0..2^ADDR_W)
//   bus        : ROM port (rom_en, rom_addr, rom_dout) and output stream
//                (out_data, out_valid, out_ready)
//   busy       : run in progress
//   done       : one-cycle pulse at run end
module rom_reader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  rom_reader_if.master      bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, FIN} state_t;

  localparam logic [2:0] LAT = 3'(ROM_LATENCY);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic [2:0]        wait_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      wait_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start && count != '0) begin
            addr_q   <= start_addr;
            remain_q <= count;
          end
        end
        ISSUE: wait_q <= LAT;
        WAIT: begin
          wait_q <= wait_q - 3'd1;
          // Capture on the edge that leaves WAIT, when ROM data is valid.
          if (wait_q <= 3'd1) data_q <= bus.rom_dout;
        end
        HOLD: begin
          if (bus.out_ready) begin
            remain_q <= remain_q - (ADDR_W+1)'(1);
            addr_q   <= addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.rom_en    = 1'b0;
    bus.rom_addr  = addr_q;
    bus.out_data  = data_q;
    bus.out_valid = 1'b0;
    busy          = (state_q != IDLE);
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (count == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        bus.rom_en = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_q <= 3'd1) state_d = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_d = (remain_q > (ADDR_W+1)'(1)) ? ISSUE : FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
